bytecode_fetch: RTL and testbench

- Upstream stage of the CPU core. It fetches the current opcode and its two argument bytes from byte-wide program memory at the CPU's program counter.
- It also fetches the 32-bit data-segment word selected by the CPU's data index (method-invocation parameters or constants).
- It presents stable op_code/arg1/arg2/dataparams values plus valid flags, and refetches automatically whenever pc or dataindex changes.

---
 rtl/bali_fetch_pkg.sv | 7 +
 rtl/bytecode_fetch_byte_assembler.sv | 41 ++++
 rtl/bytecode_fetch.sv | 205 ++++++++++++++++++++
 tb/tb_bytecode_fetch.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/bali_fetch_pkg.sv
// Shared types and constants for the bytecode fetch stage.
package bali_fetch_pkg;
  typedef enum logic [1:0] {IDLE, I_FETCH, D_FETCH} fetch_state_t;

  localparam logic [7:0]  NOP_OPCODE        = 8'h00;
  localparam logic [15:0] DEFAULT_DATA_BASE = 16'h8000;
endpackage

// File: rtl/bytecode_fetch_byte_assembler.sv
// Shift-in register that assembles N bytes big-endian; done pulses on the last byte.
module byte_assembler #(
  parameter int N = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           shift_en,
  input  logic [7:0]     din,
  output logic [8*N-1:0] word,
  output logic           done
);
  logic [8*(N-1)-1:0] shreg_q, shreg_d;
  logic [2:0]         cnt_q, cnt_d;

  // word already includes the byte arriving this cycle so the caller can commit on done
  assign word = {shreg_q, din};
  assign done = shift_en && (cnt_q == 3'(N - 1));

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (clr) begin
      shreg_d = '0;
      cnt_d   = '0;
    end else if (shift_en) begin
      shreg_d = word[8*(N-1)-1:0];
      cnt_d   = done ? 3'd0 : cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: rtl/bytecode_fetch.sv
// Fetches opcode+2 argument bytes at pc and a big-endian data word at dataindex
// from byte-wide memory, refetching whenever either input changes.
module bytecode_fetch
  import bali_fetch_pkg::*;
#(
  parameter logic [15:0] DATA_BASE = DEFAULT_DATA_BASE,
  parameter int          ADDR_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       pc,
  input  logic [15:0]       dataindex,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        op_code,
  output logic [7:0]        arg1,
  output logic [7:0]        arg2,
  output logic [31:0]       dataparams,
  output logic              instr_valid,
  output logic              data_valid
);
  fetch_state_t      state_q, state_d;
  logic [15:0]       pc_lat_q, pc_lat_d, idx_lat_q, idx_lat_d;
  logic [15:0]       fetched_pc_q, fetched_pc_d, fetched_idx_q, fetched_idx_d;
  logic              i_stale_q, i_stale_d, d_stale_q, d_stale_d;
  logic [1:0]        k_q, k_d;
  logic              iss_done_q, iss_done_d, rd_vld_q, rd_vld_d;
  logic              mem_en_q, mem_en_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        op_code_q, op_code_d, arg1_q, arg1_d, arg2_q, arg2_d;
  logic [31:0]       dataparams_q, dataparams_d;
  logic              instr_valid_q, instr_valid_d, data_valid_q, data_valid_d;

  logic              i_clr, d_clr, i_shift, d_shift, i_done, d_done;
  logic              go_i, go_d, dispatch;
  logic [23:0]       i_word;
  logic [31:0]       d_word;

  function automatic logic [ADDR_W-1:0] data_addr(input logic [15:0] idx);
    return ADDR_W'(DATA_BASE) + ADDR_W'({idx, 2'b00});
  endfunction

  assign i_shift = rd_vld_q && (state_q == I_FETCH);
  assign d_shift = rd_vld_q && (state_q == D_FETCH);

  byte_assembler #(.N(3)) u_instr_asm (
    .clk(clk), .rst(rst), .clr(i_clr), .shift_en(i_shift),
    .din(mem_rdata), .word(i_word), .done(i_done)
  );

  byte_assembler #(.N(4)) u_data_asm (
    .clk(clk), .rst(rst), .clr(d_clr), .shift_en(d_shift),
    .din(mem_rdata), .word(d_word), .done(d_done)
  );

  always_comb begin
    state_d       = state_q;
    pc_lat_d      = pc_lat_q;
    idx_lat_d     = idx_lat_q;
    fetched_pc_d  = fetched_pc_q;
    fetched_idx_d = fetched_idx_q;
    i_stale_d     = i_stale_q;
    d_stale_d     = d_stale_q;
    k_d           = k_q;
    iss_done_d    = iss_done_q;
    rd_vld_d      = mem_en_q;
    mem_en_d      = 1'b0;
    mem_addr_d    = mem_addr_q;
    op_code_d     = op_code_q;
    arg1_d        = arg1_q;
    arg2_d        = arg2_q;
    dataparams_d  = dataparams_q;
    instr_valid_d = instr_valid_q;
    data_valid_d  = data_valid_q;
    i_clr         = 1'b0;
    d_clr         = 1'b0;
    go_i          = 1'b0;
    go_d          = 1'b0;
    dispatch      = 1'b0;

    case (state_q)
      I_FETCH: begin
        if (pc != pc_lat_q) begin
          go_i = 1'b1;
        end else begin
          if (!iss_done_q) begin
            mem_en_d   = 1'b1;
            mem_addr_d = ADDR_W'(pc_lat_q) + ADDR_W'(k_q);
            k_d        = k_q + 2'd1;
            iss_done_d = (k_q == 2'd2);
          end
          if (i_done) begin
            {op_code_d, arg1_d, arg2_d} = i_word;
            instr_valid_d = 1'b1;
            fetched_pc_d  = pc_lat_q;
            i_stale_d     = 1'b0;
            dispatch      = 1'b1;
          end
        end
      end
      D_FETCH: begin
        // pc changes are deliberately ignored here; the word completes first
        if (dataindex != idx_lat_q) begin
          go_d = 1'b1;
        end else begin
          if (!iss_done_q) begin
            mem_en_d   = 1'b1;
            mem_addr_d = data_addr(idx_lat_q) + ADDR_W'(k_q);
            k_d        = k_q + 2'd1;
            iss_done_d = (k_q == 2'd3);
          end
          if (d_done) begin
            dataparams_d  = d_word;
            data_valid_d  = 1'b1;
            fetched_idx_d = idx_lat_q;
            d_stale_d     = 1'b0;
            dispatch      = 1'b1;
          end
        end
      end
      default: dispatch = 1'b1;
    endcase

    if (dispatch) begin
      if (pc != fetched_pc_d || i_stale_d)              go_i = 1'b1;
      else if (dataindex != fetched_idx_d || d_stale_d) go_d = 1'b1;
      else                                              state_d = IDLE;
    end

    // Starting a fetch issues its first byte on the same edge and drops any in-flight read
    if (go_i) begin
      state_d       = I_FETCH;
      pc_lat_d      = pc;
      instr_valid_d = 1'b0;
      mem_en_d      = 1'b1;
      mem_addr_d    = ADDR_W'(pc);
      k_d           = 2'd1;
      iss_done_d    = 1'b0;
      rd_vld_d      = 1'b0;
      i_clr         = 1'b1;
    end else if (go_d) begin
      state_d       = D_FETCH;
      idx_lat_d     = dataindex;
      data_valid_d  = 1'b0;
      mem_en_d      = 1'b1;
      mem_addr_d    = data_addr(dataindex);
      k_d           = 2'd1;
      iss_done_d    = 1'b0;
      rd_vld_d      = 1'b0;
      d_clr         = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_lat_q      <= '0;
      idx_lat_q     <= '0;
      fetched_pc_q  <= '0;
      fetched_idx_q <= '0;
      i_stale_q     <= 1'b1;
      d_stale_q     <= 1'b1;
      k_q           <= '0;
      iss_done_q    <= 1'b0;
      rd_vld_q      <= 1'b0;
      mem_en_q      <= 1'b0;
      mem_addr_q    <= '0;
      op_code_q     <= NOP_OPCODE;
      arg1_q        <= '0;
      arg2_q        <= '0;
      dataparams_q  <= '0;
      instr_valid_q <= 1'b0;
      data_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_lat_q      <= pc_lat_d;
      idx_lat_q     <= idx_lat_d;
      fetched_pc_q  <= fetched_pc_d;
      fetched_idx_q <= fetched_idx_d;
      i_stale_q     <= i_stale_d;
      d_stale_q     <= d_stale_d;
      k_q           <= k_d;
      iss_done_q    <= iss_done_d;
      rd_vld_q      <= rd_vld_d;
      mem_en_q      <= mem_en_d;
      mem_addr_q    <= mem_addr_d;
      op_code_q     <= op_code_d;
      arg1_q        <= arg1_d;
      arg2_q        <= arg2_d;
      dataparams_q  <= dataparams_d;
      instr_valid_q <= instr_valid_d;
      data_valid_q  <= data_valid_d;
    end
  end

  assign mem_en      = mem_en_q;
  assign mem_addr    = mem_addr_q;
  assign op_code     = op_code_q;
  assign arg1        = arg1_q;
  assign arg2        = arg2_q;
  assign dataparams  = dataparams_q;
  assign instr_valid = instr_valid_q;
  assign data_valid  = data_valid_q;
endmodule

// File: tb/tb_bytecode_fetch.sv
// Bench for bytecode_fetch: byte-wide memory model plus an address-arithmetic reference.
module tb_bytecode_fetch;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc, dataindex;
  logic        mem_en;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata = 8'h00;
  logic [7:0]  op_code, arg1, arg2;
  logic [31:0] dataparams;
  logic        instr_valid, data_valid;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [0:65535];

  bytecode_fetch dut (
    .clk(clk), .rst(rst), .pc(pc), .dataindex(dataindex),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .op_code(op_code), .arg1(arg1), .arg2(arg2), .dataparams(dataparams),
    .instr_valid(instr_valid), .data_valid(data_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_en) mem_rdata <= mem[mem_addr];

  function automatic logic [23:0] exp_instr(input logic [15:0] p);
    logic [15:0] a1, a2;
    a1 = 16'((32'(p) + 1) % 65536);
    a2 = 16'((32'(p) + 2) % 65536);
    return {mem[p], mem[a1], mem[a2]};
  endfunction

  function automatic logic [31:0] exp_data(input logic [15:0] idx);
    logic [15:0] a;
    logic [31:0] w;
    w = 0;
    for (int b = 0; b < 4; b++) begin
      a = 16'((32'h8000 + 4 * 32'(idx) + b) % 65536);
      w = (w << 8) | 32'(mem[a]);
    end
    return w;
  endfunction

  task automatic wait_both(input int budget, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (instr_valid && data_valid) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_timeout: valid=%b%b after %0d cycles, required 11", name, instr_valid, data_valid, budget);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; pc = 16'h0000; dataindex = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (op_code !== 8'h00 || arg1 !== 8'h00 || arg2 !== 8'h00) begin
      errors++; $display("FAIL reset_instr: got %h %h %h required 00 00 00", op_code, arg1, arg2); end
    checks++; if (dataparams !== 32'h0) begin
      errors++; $display("FAIL reset_data: got %h required 00000000", dataparams); end
    checks++; if ({instr_valid, data_valid, mem_en} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b required 000", {instr_valid, data_valid, mem_en}); end
    checks++; if (mem_addr !== 16'h0) begin
      errors++; $display("FAIL reset_addr: got %h required 0000", mem_addr); end
  endtask

  task automatic test_first_fetch();
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++; if (instr_valid !== 1'b0) begin
        errors++; $display("FAIL first_early_valid: cycle %0d got %b required 0", i, instr_valid); end
    end
    @(posedge clk); #1;
    checks++; if ({instr_valid, op_code, arg1, arg2} !== {1'b1, 24'h100507}) begin
      errors++; $display("FAIL first_instr: got %b %h%h%h required 1 100507", instr_valid, op_code, arg1, arg2); end
    wait_both(20, "first_data");
    checks++; if (dataparams !== exp_data(16'h0)) begin
      errors++; $display("FAIL first_data: got %h required %h", dataparams, exp_data(16'h0)); end
  endtask

  task automatic test_pc_change();
    @(negedge clk); pc = 16'h0003;
    @(posedge clk); #1;
    checks++; if (instr_valid !== 1'b0) begin
      errors++; $display("FAIL pcchg_drop: got %b required 0", instr_valid); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if ({instr_valid, op_code, arg1, arg2} !== {1'b0, 24'h100507}) begin
        errors++; $display("FAIL pcchg_hold: got %b %h%h%h required 0 100507", instr_valid, op_code, arg1, arg2); end
    end
    @(posedge clk); #1;
    checks++; if ({instr_valid, op_code, arg1, arg2} !== {1'b1, 24'hB80001}) begin
      errors++; $display("FAIL pcchg_new: got %b %h%h%h required 1 B80001", instr_valid, op_code, arg1, arg2); end
  endtask

  task automatic test_data();
    logic [15:0] addrs [4];
    addrs = '{16'h8008, 16'h8009, 16'h800A, 16'h800B};
    @(negedge clk); dataindex = 16'd2;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++; if ({mem_en, mem_addr} !== {1'b1, addrs[i]} || data_valid !== 1'b0) begin
        errors++; $display("FAIL data_issue%0d: got en=%b addr=%h dv=%b required 1 %h 0", i, mem_en, mem_addr, data_valid, addrs[i]); end
    end
    @(posedge clk); #1;
    checks++; if (mem_en !== 1'b0 || data_valid !== 1'b0) begin
      errors++; $display("FAIL data_tail: got en=%b dv=%b required 0 0", mem_en, data_valid); end
    @(posedge clk); #1;
    checks++; if ({data_valid, dataparams} !== {1'b1, 32'hDEADBEEF}) begin
      errors++; $display("FAIL data_word: got %b %h required 1 DEADBEEF", data_valid, dataparams); end
  endtask

  task automatic test_wrap();
    logic [15:0] addrs [3];
    addrs = '{16'hFFFF, 16'h0000, 16'h0001};
    @(negedge clk); pc = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if (mem_addr !== addrs[i]) begin
        errors++; $display("FAIL wrap_addr%0d: got %h required %h", i, mem_addr, addrs[i]); end
    end
    wait_both(20, "wrap");
    checks++; if ({op_code, arg1, arg2} !== {mem[16'hFFFF], 8'h10, 8'h05}) begin
      errors++; $display("FAIL wrap_instr: got %h%h%h required %h1005", op_code, arg1, arg2, mem[16'hFFFF]); end
  endtask

  task automatic test_abort();
    @(negedge clk); pc = 16'h0003;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk); pc = 16'h0009;
    wait_both(20, "abort");
    checks++; if ({op_code, arg1, arg2} !== 24'h2A3B4C) begin
      errors++; $display("FAIL abort_instr: got %h%h%h required 2A3B4C", op_code, arg1, arg2); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk); pc = 16'h0100; dataindex = 16'd5;
    repeat (5) @(posedge clk);
    #1;
    checks++; if ({instr_valid, data_valid} !== 2'b10 || {op_code, arg1, arg2} !== exp_instr(16'h0100)) begin
      errors++; $display("FAIL b2b_instr: got v=%b%b %h%h%h required 10 %h", instr_valid, data_valid, op_code, arg1, arg2, exp_instr(16'h0100)); end
    repeat (5) @(posedge clk);
    #1;
    checks++; if ({data_valid, dataparams} !== {1'b1, exp_data(16'd5)}) begin
      errors++; $display("FAIL b2b_data: got %b %h required 1 %h", data_valid, dataparams, exp_data(16'd5)); end
  endtask

  task automatic test_async_reset();
    @(negedge clk); dataindex = 16'd7;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if ({op_code, arg1, arg2, dataparams} !== 56'h0 || {instr_valid, data_valid, mem_en} !== 3'b000) begin
      errors++; $display("FAIL async_rst: got %h%h%h %h v=%b%b en=%b required all 0", op_code, arg1, arg2, dataparams, instr_valid, data_valid, mem_en); end
    @(negedge clk); rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++; if ({instr_valid, data_valid} !== 2'b10 || {op_code, arg1, arg2} !== exp_instr(pc)) begin
      errors++; $display("FAIL async_refetch_i: got v=%b%b %h%h%h required 10 %h", instr_valid, data_valid, op_code, arg1, arg2, exp_instr(pc)); end
    wait_both(20, "async_data");
    checks++; if (dataparams !== exp_data(16'd7)) begin
      errors++; $display("FAIL async_refetch_d: got %h required %h", dataparams, exp_data(16'd7)); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 20; it++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) != 0) pc = 16'($urandom);
      dataindex = 16'($urandom_range(0, 65535));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
        pc = 16'($urandom);
      end
      wait_both(60, "rand");
      checks++; if ({op_code, arg1, arg2} !== exp_instr(pc)) begin
        errors++; $display("FAIL rand_instr%0d: pc=%h got %h%h%h required %h", it, pc, op_code, arg1, arg2, exp_instr(pc)); end
      checks++; if (dataparams !== exp_data(dataindex)) begin
        errors++; $display("FAIL rand_data%0d: idx=%h got %h required %h", it, dataindex, dataparams, exp_data(dataindex)); end
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h10; mem[1] = 8'h05; mem[2] = 8'h07;
    mem[3] = 8'hB8; mem[4] = 8'h00; mem[5] = 8'h01;
    mem[9] = 8'h2A; mem[10] = 8'h3B; mem[11] = 8'h4C;
    mem[16'h8008] = 8'hDE; mem[16'h8009] = 8'hAD; mem[16'h800A] = 8'hBE; mem[16'h800B] = 8'hEF;

    test_reset();
    test_first_fetch();
    test_pc_change();
    test_data();
    test_wrap();
    test_abort();
    test_back_to_back();
    test_async_reset();
    test_random();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
